settings_bank_bbprx: RTL

Parametrised, double-buffered bank of serial-bus setting registers for the baseband pulse receiver.
- Serial writes land in shadow registers.
- A commit command transfers all shadows to the active outputs in a single cycle, so multi-register changes (thresholds, latencies, n_samples, mode) never take effect piecemeal.
- Commits can wait for a pulse-boundary safe point, with a timeout.
- Sits on master_clk beside master control; drives the trigger, ARP/ACP and sampling logic.

---
 rtl/bbprx_settings_pkg.sv | 45 ++++
 rtl/settings_shadow_reg.sv | 48 ++++
 rtl/settings_bank_bbprx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bbprx_settings_pkg.sv
`default_nettype none
// ============================================================================
//  Module : bbprx_settings_pkg
//  Shared command bits, FSM encoding, status layout and user register offsets
//  for the baseband pulse receiver settings bank.
//  Rev    : 1.0  initial release
// ============================================================================
package bbprx_settings_pkg;

    // Command word bits (write to BASE_ADDR + N_REGS)
    localparam int CMD_COMMIT    = 0;
    localparam int CMD_IMMEDIATE = 1;
    localparam int CMD_CLEAR     = 2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Status word bit positions (readback at rd_sel == N_REGS)
    localparam int STAT_BUSY    = 0;
    localparam int STAT_PENDING = 1;
    localparam int STAT_TIMEOUT = 2;

    // Register offsets from BASE_ADDR used by trigger, ARP/ACP and sampling
    localparam int REG_TRIG_THRESH = 0;
    localparam int REG_TRIG_HYST   = 1;
    localparam int REG_ARP_LATENCY = 2;
    localparam int REG_ACP_LATENCY = 3;
    localparam int REG_N_SAMPLES   = 4;
    localparam int REG_MODE        = 5;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic pend,
                                                input logic tflag);
        logic [31:0] w;
        w               = 32'd0;
        w[STAT_BUSY]    = busy;
        w[STAT_PENDING] = pend;
        w[STAT_TIMEOUT] = tflag;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/settings_shadow_reg.sv
`default_nettype none
// ============================================================================
//  Module : settings_shadow_reg
//  One shadow/active register pair with load, clear and change detect.
//  Rev    : 1.0  initial release
// ============================================================================
module settings_shadow_reg #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             master_clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_load,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_active,
    output logic             o_changed
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_changed;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow  <= DEFAULT;
            r_active  <= DEFAULT;
            r_changed <= 1'b0;
        end else if (i_clear) begin
            r_shadow  <= DEFAULT;
            r_active  <= DEFAULT;
            r_changed <= 1'b0;
        end else begin
            if (i_wr_en)
                r_shadow <= i_wr_data;
            if (i_load)
                r_active <= r_shadow;
            // Compare uses pre-edge shadow so a same-edge write waits for the next commit
            r_changed <= i_load && (r_shadow != r_active);
        end
    end

    assign o_active  = r_active;
    assign o_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/settings_bank_bbprx.sv
`default_nettype none
// ============================================================================
//  Module : settings_bank_bbprx
//  Double-buffered serial settings bank with atomic, safe-point gated commit.
//  Rev    : 1.0  initial release
// ============================================================================
module settings_bank_bbprx
    import bbprx_settings_pkg::*;
#(
    parameter logic [6:0]              BASE_ADDR = 7'd32,
    parameter int                      N_REGS    = 16,
    parameter int                      WIDTH     = 16,
    parameter logic [N_REGS*WIDTH-1:0] DEFAULTS  = '0,
    parameter logic [15:0]             TIMEOUT   = 16'd0
) (
    input  logic                    master_clk,
    input  logic                    reset_n,
    input  logic [6:0]              serial_addr,
    input  logic [31:0]             serial_data,
    input  logic                    serial_strobe,
    input  logic                    safe,
    output logic [N_REGS*WIDTH-1:0] active,
    output logic [N_REGS-1:0]       changed,
    output logic                    commit_done,
    output logic                    pending,
    output logic                    timeout_flag,
    input  logic [6:0]              rd_sel,
    output logic [31:0]             rd_data
);

    localparam logic [6:0]  c_CMD_ADDR = 7'(int'(BASE_ADDR) + N_REGS);
    localparam logic [15:0] c_TO_LAST  = TIMEOUT - 16'd1;

    if ((int'(BASE_ADDR) + N_REGS > 127) || (N_REGS < 1) || (N_REGS > 64) ||
        (WIDTH < 1) || (WIDTH > 32)) begin : g_param_check
        $error("settings_bank_bbprx: illegal BASE_ADDR/N_REGS/WIDTH combination");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_tflag;
    logic        w_tflag_nxt;
    logic        r_commit_done;
    logic [31:0] r_rd_data;
    logic [31:0] w_rd_next;
    logic        w_load;
    logic        w_clear;
    logic        w_cmd_hit;
    logic [31:0] w_rd_arr [64];
    logic        w_unused_data;

    assign w_cmd_hit     = serial_strobe && (serial_addr == c_CMD_ADDR);
    assign w_unused_data = ^serial_data;

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        localparam logic [6:0] c_ADDR = 7'(int'(BASE_ADDR) + i);
        settings_shadow_reg #(
            .WIDTH   (WIDTH),
            .DEFAULT (DEFAULTS[i*WIDTH +: WIDTH])
        ) u_reg (
            .master_clk (master_clk),
            .reset_n    (reset_n),
            .i_wr_en    (serial_strobe && (serial_addr == c_ADDR)),
            .i_wr_data  (serial_data[WIDTH-1:0]),
            .i_load     (w_load),
            .i_clear    (w_clear),
            .o_active   (active[i*WIDTH +: WIDTH]),
            .o_changed  (changed[i])
        );
    end

    for (genvar i = 0; i < 64; i++) begin : g_rd
        if (i < N_REGS) begin : g_used
            assign w_rd_arr[i] = 32'(active[i*WIDTH +: WIDTH]);
        end else begin : g_empty
            assign w_rd_arr[i] = 32'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tflag_nxt = r_tflag;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        if (w_cmd_hit && serial_data[CMD_CLEAR]) begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
            w_tflag_nxt = 1'b0;
            w_cnt_nxt   = 16'd0;
        end else if (w_cmd_hit && serial_data[CMD_COMMIT] && serial_data[CMD_IMMEDIATE]) begin
            w_load      = 1'b1;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hit && serial_data[CMD_COMMIT]) begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = 16'd0;
                    end
                end
                ST_PENDING: begin
                    // Further commit requests here neither restart nor shorten the wait
                    if (safe) begin
                        w_load      = 1'b1;
                        w_tflag_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else if ((TIMEOUT != 16'd0) && (r_cnt == c_TO_LAST)) begin
                        w_load      = 1'b1;
                        w_tflag_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_next = 32'd0;
        if (rd_sel < 7'(N_REGS))
            w_rd_next = w_rd_arr[rd_sel[5:0]];
        else if (rd_sel == 7'(N_REGS))
            w_rd_next = status_word(r_state != ST_IDLE, r_state == ST_PENDING, r_tflag);
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 16'd0;
            r_tflag       <= 1'b0;
            r_commit_done <= 1'b0;
            r_rd_data     <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_tflag       <= w_tflag_nxt;
            r_commit_done <= w_load;
            r_rd_data     <= w_rd_next;
        end
    end

    assign commit_done  = r_commit_done;
    assign pending      = (r_state == ST_PENDING);
    assign timeout_flag = r_tflag;
    assign rd_data      = r_rd_data;

endmodule
`default_nettype wire
